cpu_core: RTL and testbench
===========================

Name: cpu_core

Overview:
Per-CPU transaction source for the multi-simulation example. After reset it emits a fixed number of 64-bit data words over a valid/ready stream; the multisim client bridge consumes them and forwards them to a remote server. Each word is tagged with the CPU index and a sequence number. A sticky done flag tells the top level to end the simulation.

Parameters:
N_TRANSACTIONS, 16, number of words to send; legal range 1..2^32-1.
GAP_MASK, 4'h3, AND-mask on LFSR low bits giving idle cycles between words; 0 means back-to-back.
START_DELAY, 2, idle cycles after reset release before the first word is offered.

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
cpu_index  input  32  CPU identifier; static after reset.
data_rdy  input  1  sink ready.
data_vld  output  1  word valid.
data  output  64  payload: {cpu_index, seq[31:0]}.
transactions_done  output  1  sticky; high once all words are transferred.

Behaviour:
- Reset (async assert, sync release): data_vld=0, data=0, transactions_done=0, seq=0, LFSR=16'h0001, state=IDLE, delay counter=START_DELAY.
- States are IDLE, GAP, SEND, DONE.
- IDLE:
  - First cycle: load LFSR seed = cpu_index[15:0] ^ 16'hACE1; if the result is 0, use 16'h0001.
  - Count down START_DELAY cycles, then enter SEND.
  - In SEND, drive data_vld=1 and data={cpu_index, seq}.
- SEND:
  - Transfer occurs on a rising edge with data_vld && data_rdy.
  - While data_vld=1 and data_rdy=0, data is held stable; data_vld is never withdrawn.
  - On transfer, seq increments and the LFSR advances one step.
  - Polynomial: x^16+x^14+x^13+x^11+1, Fibonacci form, shift left, feedback = b15^b13^b12^b10 into bit0.
  - gap = new_lfsr[3:0] & GAP_MASK.
- After a transfer:
  - If seq+1 == N_TRANSACTIONS: enter DONE, data_vld=0, transactions_done=1 on the same edge.
  - Else if gap==0: stay in SEND with data_vld=1 and the new data on the next cycle (back-to-back, one word per cycle).
  - Else: data_vld=0 and enter GAP for exactly gap cycles, then SEND.
- DONE is terminal until reset: data_vld=0; transactions_done stays 1; data holds the last word; data_rdy is ignored.
- data_rdy may toggle arbitrarily. A data_rdy high while data_vld=0 has no effect.
- Latency from reset release to first data_vld: START_DELAY+1 cycles (the +1 is the seed-load cycle).
- seq is 32 bits and does not wrap within the legal N_TRANSACTIONS range.
- Reset asserted mid-transfer or in DONE aborts immediately to reset values. The sequence restarts from seq=0.
- No combinational path from data_rdy to data_vld or data; all outputs are registered.

Test Plan:
- cpu_index=3, GAP_MASK=0, N=4, data_rdy tied 1 -> after 3 cycles data_vld high for 4 consecutive cycles with data 0x00000003_00000000..00000003_00000003; transactions_done rises on the edge of the last transfer; data_vld=0 afterwards.
- Backpressure: hold data_rdy=0 for 5 cycles while data_vld=1 -> data and data_vld stable throughout; transfer on the first edge with rdy=1; no word skipped or duplicated.
- Default GAP_MASK, cpu_index=0 (seed 0xACE1), N=16, random data_rdy -> 16 words with seq 0..15 in order; idle gaps match the LFSR model; transactions_done=1 after the 16th.
- Seed-zero corner: cpu_index=32'h0000ACE1 -> seed forced to 0x0001; the sequence matches the model; no lock-up.
- Reset mid-stream: assert rst_n=0 after the 2nd transfer -> outputs zero immediately (asynchronous); after release the stream restarts at seq=0.
- N=1: exactly one word {cpu_index,0}; done after it; later data_rdy pulses cause no further data_vld.

Source files
------------

// File: rtl/cpu_core.sv
// Per-CPU transaction source: emits N_TRANSACTIONS tagged 64-bit words on a
// valid/ready stream with LFSR-driven idle gaps, then raises a sticky done flag.
module cpu_core #(
  parameter logic [31:0] N_TRANSACTIONS = 32'd16,
  parameter logic [3:0]  GAP_MASK       = 4'h3,
  parameter int unsigned START_DELAY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_index,
  input  logic        data_rdy,
  output logic        data_vld,
  output logic [63:0] data,
  output logic        transactions_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] START_DELAY_W = START_DELAY[31:0];

  // x^16+x^14+x^13+x^11+1, Fibonacci form shifting left
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  function automatic logic [15:0] lfsr_seed(input logic [31:0] idx);
    logic [15:0] s;
    s = idx[15:0] ^ 16'hACE1;
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] delay_q, delay_d;
  logic [3:0]  gap_q, gap_d;
  logic        seeded_q, seeded_d;
  logic        vld_q, vld_d;
  logic        done_q, done_d;
  logic [63:0] data_q, data_d;
  logic [15:0] lfsr_nxt_s;
  logic [3:0]  gap_nxt_s;
  logic        xfer_s;

  // Next-state and output computation
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seq_d      = seq_q;
    delay_d    = delay_q;
    gap_d      = gap_q;
    seeded_d   = seeded_q;
    vld_d      = vld_q;
    done_d     = done_q;
    data_d     = data_q;
    lfsr_nxt_s = lfsr_step(lfsr_q);
    gap_nxt_s  = lfsr_nxt_s[3:0] & GAP_MASK;
    xfer_s     = vld_q & data_rdy;

    case (state_q)
      IDLE: begin
        if (!seeded_q) begin
          lfsr_d   = lfsr_seed(cpu_index);
          seeded_d = 1'b1;
          if (delay_q == 32'd0) begin
            state_d = SEND;
            vld_d   = 1'b1;
            data_d  = {cpu_index, seq_q};
          end else begin
            delay_d = delay_q;
          end
        end else if (delay_q <= 32'd1) begin
          delay_d = 32'd0;
          state_d = SEND;
          vld_d   = 1'b1;
          data_d  = {cpu_index, seq_q};
        end else begin
          delay_d = delay_q - 32'd1;
        end
      end
      SEND: begin
        if (xfer_s) begin
          seq_d  = seq_q + 32'd1;
          lfsr_d = lfsr_nxt_s;
          if (seq_q + 32'd1 == N_TRANSACTIONS) begin
            state_d = DONE;
            vld_d   = 1'b0;
            done_d  = 1'b1;
          end else if (gap_nxt_s == 4'd0) begin
            data_d = {cpu_index, seq_q + 32'd1};
          end else begin
            state_d = GAP;
            vld_d   = 1'b0;
            gap_d   = gap_nxt_s;
          end
        end else begin
          vld_d = 1'b1;
        end
      end
      GAP: begin
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = SEND;
          vld_d   = 1'b1;
          data_d  = {cpu_index, seq_q};
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      DONE: begin
        vld_d  = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= 16'h0001;
      seq_q    <= 32'd0;
      delay_q  <= START_DELAY_W;
      gap_q    <= 4'd0;
      seeded_q <= 1'b0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= 64'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      seq_q    <= seq_d;
      delay_q  <= delay_d;
      gap_q    <= gap_d;
      seeded_q <= seeded_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      data_q   <= data_d;
    end
  end

  assign data_vld          = vld_q;
  assign data              = data_q;
  assign transactions_done = done_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core: three instances cover back-to-back
// streaming (N=4, no gaps), the default gapped stream (N=16) and the N=1 case.
module tb_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        a_rst_n, a_rdy, a_vld, a_done;
  logic [31:0] a_idx;
  logic [63:0] a_data;
  logic        b_rst_n, b_rdy, b_vld, b_done;
  logic [31:0] b_idx;
  logic [63:0] b_data;
  logic        c_rst_n, c_rdy, c_vld, c_done;
  logic [31:0] c_idx;
  logic [63:0] c_data;

  cpu_core #(.N_TRANSACTIONS(32'd4), .GAP_MASK(4'h0), .START_DELAY(2)) u_b2b (
    .clk(clk), .rst_n(a_rst_n), .cpu_index(a_idx), .data_rdy(a_rdy),
    .data_vld(a_vld), .data(a_data), .transactions_done(a_done));

  cpu_core u_dut (
    .clk(clk), .rst_n(b_rst_n), .cpu_index(b_idx), .data_rdy(b_rdy),
    .data_vld(b_vld), .data(b_data), .transactions_done(b_done));

  cpu_core #(.N_TRANSACTIONS(32'd1)) u_one (
    .clk(clk), .rst_n(c_rst_n), .cpu_index(c_idx), .data_rdy(c_rdy),
    .data_vld(c_vld), .data(c_data), .transactions_done(c_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_rdy = 1'b1; b_rdy = 1'b1; c_rdy = 1'b1;
    a_idx = 32'd3; b_idx = 32'd0; c_idx = 32'h12345678;
    tick();
    tick();
    n_checks++;
    if ({a_vld, a_done, a_data} !== 66'd0) begin
      n_fail++; $display("FAIL reset_a: vld=%b done=%b data=%h, want all zero", a_vld, a_done, a_data);
    end
    n_checks++;
    if ({b_vld, b_done, b_data} !== 66'd0) begin
      n_fail++; $display("FAIL reset_b: vld=%b done=%b data=%h, want all zero", b_vld, b_done, b_data);
    end
    n_checks++;
    if ({c_vld, c_done, c_data} !== 66'd0) begin
      n_fail++; $display("FAIL reset_c: vld=%b done=%b data=%h, want all zero", c_vld, c_done, c_data);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_vld, exp_done;
    logic [63:0] exp_data;
    a_idx = 32'd3; a_rdy = 1'b1; a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_vld  = (k >= 3) && (k <= 6);
      exp_done = (k >= 7);
      if (k < 3)       exp_data = 64'd0;
      else if (k <= 6) exp_data = {32'd3, 32'(k - 3)};
      else             exp_data = {32'd3, 32'd3};
      n_checks++;
      if (a_vld !== exp_vld || a_done !== exp_done || a_data !== exp_data) begin
        n_fail++;
        $display("FAIL b2b cycle %0d: vld=%b done=%b data=%h, want vld=%b done=%b data=%h",
                 k, a_vld, a_done, a_data, exp_vld, exp_done, exp_data);
      end
    end
  endtask

  task automatic test_backpressure();
    int waited;
    a_idx = 32'd3; a_rdy = 1'b0; a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    waited = 0;
    while (a_vld !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    n_checks++;
    if (a_vld !== 1'b1) begin
      n_fail++; $display("FAIL bp_first_vld: vld=%b after %0d cycles, want 1", a_vld, waited);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (a_vld !== 1'b1 || a_data !== {32'd3, 32'd0}) begin
        n_fail++; $display("FAIL bp_hold %0d: vld=%b data=%h, want vld=1 data=%h", i, a_vld, a_data, {32'd3, 32'd0});
      end
    end
    a_rdy = 1'b1;
    tick();
    n_checks++;
    if (a_vld !== 1'b1 || a_data !== {32'd3, 32'd1}) begin
      n_fail++; $display("FAIL bp_after_release: vld=%b data=%h, want vld=1 data=%h", a_vld, a_data, {32'd3, 32'd1});
    end
    tick();
    a_rdy = 1'b0;
    tick();
    n_checks++;
    if (a_vld !== 1'b1 || a_data !== {32'd3, 32'd2}) begin
      n_fail++; $display("FAIL bp_mid_stall: vld=%b data=%h, want vld=1 data=%h", a_vld, a_data, {32'd3, 32'd2});
    end
    a_rdy = 1'b1;
    tick();
    n_checks++;
    if (a_vld !== 1'b1 || a_data !== {32'd3, 32'd3}) begin
      n_fail++; $display("FAIL bp_last_word: vld=%b data=%h, want vld=1 data=%h", a_vld, a_data, {32'd3, 32'd3});
    end
    tick();
    n_checks++;
    if (a_vld !== 1'b0 || a_done !== 1'b1 || a_data !== {32'd3, 32'd3}) begin
      n_fail++; $display("FAIL bp_done: vld=%b done=%b data=%h, want vld=0 done=1 data=%h", a_vld, a_done, a_data, {32'd3, 32'd3});
    end
  endtask

  task automatic test_reset_mid_stream();
    a_idx = 32'd3; a_rdy = 1'b1; a_rst_n = 1'b0;
    tick();
    a_rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    n_checks++;
    if (a_vld !== 1'b1 || a_data !== {32'd3, 32'd2}) begin
      n_fail++; $display("FAIL mid_before_reset: vld=%b data=%h, want vld=1 data=%h", a_vld, a_data, {32'd3, 32'd2});
    end
    a_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_vld, a_done, a_data} !== 66'd0) begin
      n_fail++; $display("FAIL mid_async_reset: vld=%b done=%b data=%h, want all zero", a_vld, a_done, a_data);
    end
    tick();
    a_rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    n_checks++;
    if (a_vld !== 1'b1 || a_data !== {32'd3, 32'd0}) begin
      n_fail++; $display("FAIL mid_restart: vld=%b data=%h, want vld=1 data=%h", a_vld, a_data, {32'd3, 32'd0});
    end
  endtask

  // Gapped stream with random ready, checked cycle by cycle against an LFSR model
  task automatic test_stream(input logic [31:0] idx);
    logic [15:0] m_lfsr;
    logic [31:0] m_seq;
    logic [3:0]  m_gap;
    logic        m_vld, m_done;
    int          words, post, cyc;
    b_idx = idx; b_rdy = 1'b0; b_rst_n = 1'b0;
    tick();
    b_rst_n = 1'b1;
    m_lfsr = idx[15:0] ^ 16'hACE1;
    if (m_lfsr == 16'h0000) m_lfsr = 16'h0001;
    tick();
    tick();
    n_checks++;
    if (b_vld !== 1'b0) begin
      n_fail++; $display("FAIL stream_%h_latency: vld=%b two cycles after reset, want 0", idx, b_vld);
    end
    tick();
    m_vld = 1'b1; m_done = 1'b0; m_seq = 32'd0; m_gap = 4'd0;
    words = 0; post = 0; cyc = 0;
    while (cyc < 400 && post < 8) begin
      n_checks++;
      if (b_vld !== m_vld || b_done !== m_done ||
          ((m_vld || m_done) && b_data !== {idx, m_seq})) begin
        n_fail++;
        $display("FAIL stream_%h cycle %0d: vld=%b done=%b data=%h, want vld=%b done=%b seq=%0d",
                 idx, cyc, b_vld, b_done, b_data, m_vld, m_done, m_seq);
      end
      b_rdy = 1'($urandom_range(0, 1));
      if (m_done) begin
        post++;
      end else if (m_vld && b_rdy) begin
        words++;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        if (m_seq == 32'd15) begin
          m_done = 1'b1;
          m_vld  = 1'b0;
        end else begin
          m_seq = m_seq + 32'd1;
          m_gap = m_lfsr[3:0] & 4'h3;
          m_vld = (m_gap == 4'd0);
        end
      end else if (!m_vld) begin
        m_gap = m_gap - 4'd1;
        m_vld = (m_gap == 4'd0);
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (b_done !== 1'b1 || words != 16) begin
      n_fail++; $display("FAIL stream_%h_end: done=%b words=%0d, want done=1 words=16", idx, b_done, words);
    end
  endtask

  task automatic test_n_one();
    c_idx = 32'h12345678; c_rdy = 1'b1; c_rst_n = 1'b0;
    tick();
    c_rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    n_checks++;
    if (c_vld !== 1'b1 || c_done !== 1'b0 || c_data !== {32'h12345678, 32'd0}) begin
      n_fail++; $display("FAIL n1_word: vld=%b done=%b data=%h, want vld=1 done=0 data=%h", c_vld, c_done, c_data, {32'h12345678, 32'd0});
    end
    tick();
    n_checks++;
    if (c_vld !== 1'b0 || c_done !== 1'b1 || c_data !== {32'h12345678, 32'd0}) begin
      n_fail++; $display("FAIL n1_done: vld=%b done=%b data=%h, want vld=0 done=1 data=%h", c_vld, c_done, c_data, {32'h12345678, 32'd0});
    end
    for (int k = 0; k < 10; k++) begin
      c_rdy = k[0];
      tick();
      n_checks++;
      if (c_vld !== 1'b0 || c_done !== 1'b1 || c_data !== {32'h12345678, 32'd0}) begin
        n_fail++; $display("FAIL n1_after %0d: vld=%b done=%b data=%h, want vld=0 done=1 data unchanged", k, c_vld, c_done, c_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stream();
    test_stream(32'h00000000);
    test_stream(32'h0000ACE1);
    test_n_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
